// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the MEM stage. Holds the access-size
//                encodings carried on i_memSize, the default data-memory
//                depth, and a helper that decides whether an access is
//                misaligned for its size.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Access-size encodings. 2'b10 is unused and is treated as a word access.
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b11;

    // Default data-memory depth, in 32-bit words (must be a power of two).
    localparam int DEFAULT_DEPTH_WORDS = 256;

    // A half access needs an even address. A word access needs a multiple of
    // four. A byte access is always aligned.
    function automatic logic mem_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lsb);
        logic mis;
        case (size)
            MEM_SIZE_BYTE: mis = 1'b0;
            MEM_SIZE_HALF: mis = addr_lsb[0];
            default:       mis = (addr_lsb != 2'b00);
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Bundle of the EX/MEM inputs and MEM/WB outputs of the MEM
//                stage.
//                slave  : used by mem_stage (consumes i_*, produces o_*)
//                master : used by the driving side (produces i_*)
//                Inputs : i_pcplus4, i_result, i_dato2, i_carry,
//                         i_writeRegister, i_memToReg, i_regWrite,
//                         i_memWrite, i_memRead, i_memSize, i_memUnsigned,
//                         i_stall
//                Outputs: o_forward_dato_mem, o_pcplus4, o_result,
//                         o_readData, o_carry, o_writeRegister, o_memToReg,
//                         o_regWrite, o_addrError
//                With MEM_DEBUG_PORT_EN defined, the bundle also carries
//                i_dbg_addr / o_dbg_data.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
);

    // EX/MEM latch side
    logic [31:0] i_pcplus4;
    logic [31:0] i_result;
    logic [31:0] i_dato2;
    logic        i_carry;
    logic [4:0]  i_writeRegister;
    logic        i_memToReg;
    logic        i_regWrite;
    logic        i_memWrite;
    logic        i_memRead;
    logic [1:0]  i_memSize;
    logic        i_memUnsigned;
    logic        i_stall;

    // Forwarding and MEM/WB latch side
    logic [31:0] o_forward_dato_mem;
    logic [31:0] o_pcplus4;
    logic [31:0] o_result;
    logic [31:0] o_readData;
    logic        o_carry;
    logic [4:0]  o_writeRegister;
    logic        o_memToReg;
    logic        o_regWrite;
    logic        o_addrError;

`ifdef MEM_DEBUG_PORT_EN
    localparam int C_DBG_ADDR_W = $clog2(DEPTH_WORDS);
    logic [C_DBG_ADDR_W-1:0] i_dbg_addr;
    logic [31:0]             o_dbg_data;
`endif

    modport slave (
        input  i_pcplus4, i_result, i_dato2, i_carry, i_writeRegister,
               i_memToReg, i_regWrite, i_memWrite, i_memRead, i_memSize,
               i_memUnsigned, i_stall,
`ifdef MEM_DEBUG_PORT_EN
        input  i_dbg_addr,
        output o_dbg_data,
`endif
        output o_forward_dato_mem, o_pcplus4, o_result, o_readData, o_carry,
               o_writeRegister, o_memToReg, o_regWrite, o_addrError
    );

    modport master (
        output i_pcplus4, i_result, i_dato2, i_carry, i_writeRegister,
               i_memToReg, i_regWrite, i_memWrite, i_memRead, i_memSize,
               i_memUnsigned, i_stall,
`ifdef MEM_DEBUG_PORT_EN
        output i_dbg_addr,
        input  o_dbg_data,
`endif
        input  o_forward_dato_mem, o_pcplus4, o_result, o_readData, o_carry,
               o_writeRegister, o_memToReg, o_regWrite, o_addrError
    );

endinterface
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Word-organised data memory with per-byte write enables and an
//                asynchronous read port. The contents are never cleared.
//                Ports  : clk, i_we, i_byte_en[3:0], i_addr, i_wdata[31:0],
//                         o_rdata[31:0] (combinational read of i_addr)
//                With MEM_DEBUG_PORT_EN defined, the module also has rst,
//                i_dbg_addr and o_dbg_data. o_dbg_data is a registered read of
//                i_dbg_addr, and reset clears it to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module data_memory
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  wire logic              clk,
`ifdef MEM_DEBUG_PORT_EN
    input  wire logic              rst,
    input  wire logic [ADDR_W-1:0] i_dbg_addr,
    output      logic [31:0]       o_dbg_data,
`endif
    input  wire logic              i_we,
    input  wire logic [3:0]        i_byte_en,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_wdata,
    output      logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Lane l is bits [8l+7:8l], so byte address 4n+l goes to lane l
    // (little-endian).
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < 4; l++) begin
                if (i_byte_en[l]) begin
                    r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
                end
            end
        end
    end

    // The read is asynchronous, so a read and a write of the same word in
    // one cycle return the contents from before the write.
    assign o_rdata = r_mem[i_addr];

`ifdef MEM_DEBUG_PORT_EN
    logic [31:0] r_dbg_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_data <= 32'd0;
        end else begin
            r_dbg_data <= r_mem[i_dbg_addr];
        end
    end

    assign o_dbg_data = r_dbg_data;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MIPS memory-access stage. It performs byte, half and word
//                loads and stores against data_memory, sign- or zero-extends
//                loads, and registers the MEM/WB latch. It also raises a
//                sticky flag on a misaligned access.
//                Params : DEPTH_WORDS (data-memory depth in 32-bit words,
//                         power of two)
//                Ports  : clk, rst (synchronous, active high), and bus
//                         (mem_stage_if.slave)
//                  bus.o_forward_dato_mem : combinational copy of i_result
//                                           for EX forwarding
//                  bus.o_*                : registered MEM/WB latch outputs
//                  bus.o_addrError        : sticky misalignment flag, cleared
//                                           only by reset
//                Optional: MEM_DEBUG_PORT_EN adds bus.i_dbg_addr and
//                          bus.o_dbg_data (registered debug read).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input wire logic  clk,
    input wire logic  rst,
    mem_stage_if.slave bus
);

    localparam int C_ADDR_W = $clog2(DEPTH_WORDS);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]         w_addr;
    logic [C_ADDR_W-1:0] w_word;
    logic                w_mis;
    logic                w_access;
    logic                w_we;

    assign w_addr   = bus.i_result;
    // Address bits above the memory size are ignored, so addresses wrap
    // around.
    assign w_word   = w_addr[C_ADDR_W+1:2];
    assign w_mis    = mem_misaligned(bus.i_memSize, w_addr[1:0]);
    assign w_access = bus.i_memRead | bus.i_memWrite;

    // A write is blocked by a stall, by a misaligned address, and by reset
    // in the same cycle.
    assign w_we = bus.i_memWrite & ~bus.i_stall & ~w_mis & ~rst;

    // The high address bits are intentionally unused (wrap-around).
    logic w_unused;
    assign w_unused = &{1'b0, w_addr[31:C_ADDR_W+2]};

    // ------------------------------------------------------------------
    // Store lane steering: the data is replicated across all lanes, and the
    // byte enables choose which lanes are written.
    // ------------------------------------------------------------------
    logic [3:0]  w_byte_en;
    logic [31:0] w_wdata;

    always_comb begin
        w_byte_en = 4'b1111;
        w_wdata   = bus.i_dato2;
        case (bus.i_memSize)
            MEM_SIZE_BYTE: begin
                w_byte_en = 4'b0001 << w_addr[1:0];
                w_wdata   = {4{bus.i_dato2[7:0]}};
            end
            MEM_SIZE_HALF: begin
                w_byte_en = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{bus.i_dato2[15:0]}};
            end
            default: begin
                w_byte_en = 4'b1111;
                w_wdata   = bus.i_dato2;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0] w_rdata;

    data_memory #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (C_ADDR_W)
    ) u_data_memory (
        .clk        (clk),
`ifdef MEM_DEBUG_PORT_EN
        .rst        (rst),
        .i_dbg_addr (bus.i_dbg_addr),
        .o_dbg_data (bus.o_dbg_data),
`endif
        .i_we       (w_we),
        .i_byte_en  (w_byte_en),
        .i_addr     (w_word),
        .i_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    // ------------------------------------------------------------------
    // Load extraction: shift the addressed lane down to bit 0, then extend.
    // ------------------------------------------------------------------
    logic [31:0] w_shifted;
    logic        w_sign_b;
    logic        w_sign_h;
    logic [31:0] w_load;

    assign w_shifted = w_rdata >> {w_addr[1:0], 3'b000};
    assign w_sign_b  = ~bus.i_memUnsigned & w_shifted[7];
    assign w_sign_h  = ~bus.i_memUnsigned & w_shifted[15];

    always_comb begin
        w_load = w_rdata;
        case (bus.i_memSize)
            MEM_SIZE_BYTE: w_load = {{24{w_sign_b}}, w_shifted[7:0]};
            MEM_SIZE_HALF: w_load = {{16{w_sign_h}}, w_shifted[15:0]};
            default:       w_load = w_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB latch and the sticky misalignment flag
    // ------------------------------------------------------------------
    logic [31:0] r_pcplus4;
    logic [31:0] r_result;
    logic [31:0] r_read_data;
    logic        r_carry;
    logic [4:0]  r_write_register;
    logic        r_mem_to_reg;
    logic        r_reg_write;
    logic        r_addr_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcplus4        <= 32'd0;
            r_result         <= 32'd0;
            r_read_data      <= 32'd0;
            r_carry          <= 1'b0;
            r_write_register <= 5'd0;
            r_mem_to_reg     <= 1'b0;
            r_reg_write      <= 1'b0;
            r_addr_error     <= 1'b0;
        end else if (!bus.i_stall) begin
            r_pcplus4        <= bus.i_pcplus4;
            r_result         <= bus.i_result;
            r_read_data      <= (bus.i_memRead && !w_mis) ? w_load : 32'd0;
            r_carry          <= bus.i_carry;
            r_write_register <= bus.i_writeRegister;
            r_mem_to_reg     <= bus.i_memToReg;
            r_reg_write      <= bus.i_regWrite;
            r_addr_error     <= r_addr_error | (w_access & w_mis);
        end
    end

    assign bus.o_forward_dato_mem = bus.i_result;
    assign bus.o_pcplus4          = r_pcplus4;
    assign bus.o_result           = r_result;
    assign bus.o_readData         = r_read_data;
    assign bus.o_carry            = r_carry;
    assign bus.o_writeRegister    = r_write_register;
    assign bus.o_memToReg         = r_mem_to_reg;
    assign bus.o_regWrite         = r_reg_write;
    assign bus.o_addrError        = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage (DEPTH_WORDS = 256).
//                It applies directed load/store vectors with hand-computed
//                read data. A MEM/WB latch model queues the expected outputs,
//                and a monitor on the falling edge pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;
    import mips_pkg::*;

    localparam logic [1:0] B = MEM_SIZE_BYTE;
    localparam logic [1:0] H = MEM_SIZE_HALF;
    localparam logic [1:0] W = MEM_SIZE_WORD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if #(.DEPTH_WORDS(256)) bus ();

    mem_stage #(.DEPTH_WORDS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MEM_DEBUG_PORT_EN
    initial bus.i_dbg_addr = '0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] rd;
        logic        carry;
        logic [4:0]  wreg;
        logic        m2r;
        logic        rw;
        logic        err;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each queued expectation in the cycle it becomes due.
    always @(negedge clk) begin
        exp_t  e;
        string n;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n = qn.pop_front();
            if (e.cyc < cyc) begin
                chk({n, "/stale"}, 32'(e.cyc), 32'(cyc));
            end else begin
                chk({n, "/readData"}, bus.o_readData, e.rd);
                chk({n, "/addrError"}, 32'(bus.o_addrError), 32'(e.err));
                chk({n, "/pcplus4"}, bus.o_pcplus4, e.pc);
                chk({n, "/result"}, bus.o_result, e.res);
                chk({n, "/ctrl"}, {24'd0, bus.o_carry, bus.o_writeRegister, bus.o_memToReg, bus.o_regWrite},
                    {24'd0, e.carry, e.wreg, e.m2r, e.rw});
            end
        end
    end

    // Model of the MEM/WB latch
    logic [31:0] m_pc = 0, m_res = 0, m_rd = 0;
    logic        m_carry = 0, m_m2r = 0, m_rw = 0, m_err = 0;
    logic [4:0]  m_wreg = 0;
    logic [31:0] pc_ctr = 32'h0040_0000;

    function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b01 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
    endfunction

    task automatic vec(input string name, input logic r, input logic st,
                       input logic rd, input logic wr, input logic uns,
                       input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd);
        exp_t e;
        @(posedge clk);
        #1;
        pc_ctr                 = pc_ctr + 32'd4;
        rst                    = r;
        bus.i_stall            = st;
        bus.i_memRead          = rd;
        bus.i_memWrite         = wr;
        bus.i_memUnsigned      = uns;
        bus.i_memSize          = sz;
        bus.i_result           = addr;
        bus.i_dato2            = data;
        bus.i_pcplus4          = pc_ctr;
        bus.i_carry            = ^addr;
        bus.i_writeRegister    = addr[6:2] ^ 5'd3;
        bus.i_memToReg         = rd;
        bus.i_regWrite         = rd | ~wr;
        #1;
        chk({name, "/fwd"}, bus.o_forward_dato_mem, addr);
        if (r) begin
            m_pc = 0; m_res = 0; m_rd = 0; m_carry = 0;
            m_wreg = 0; m_m2r = 0; m_rw = 0; m_err = 0;
        end else if (!st) begin
            m_pc    = pc_ctr;
            m_res   = addr;
            m_rd    = exp_rd;
            m_carry = ^addr;
            m_wreg  = addr[6:2] ^ 5'd3;
            m_m2r   = rd;
            m_rw    = rd | ~wr;
            m_err   = m_err | ((rd | wr) & misaligned(sz, addr));
        end
        e.cyc = cyc + 1; e.pc = m_pc; e.res = m_res; e.rd = m_rd;
        e.carry = m_carry; e.wreg = m_wreg; e.m2r = m_m2r; e.rw = m_rw; e.err = m_err;
        q.push_back(e);
        qn.push_back(name);
    endtask

    initial begin
        bus.i_stall = 0; bus.i_memRead = 0; bus.i_memWrite = 0; bus.i_memUnsigned = 0;
        bus.i_memSize = W; bus.i_result = 0; bus.i_dato2 = 0; bus.i_pcplus4 = 0;
        bus.i_carry = 0; bus.i_writeRegister = 0; bus.i_memToReg = 0; bus.i_regWrite = 0;

        //   name         rst st rd wr un sz addr          data          expected readData
        vec("rst0",        1, 0, 0, 0, 0, W, 32'h0,       32'h0,        32'h0);
        vec("sw0",         0, 0, 0, 1, 0, W, 32'h0,       32'h11111111, 32'h0);
        vec("rst_stall",   1, 1, 0, 0, 0, W, 32'h4,       32'h0,        32'h0);
        vec("rst_wr",      1, 0, 0, 1, 0, W, 32'h0,       32'h22222222, 32'h0);
        vec("lw0",         0, 0, 1, 0, 0, W, 32'h0,       32'h0,        32'h11111111);
        vec("sw10",        0, 0, 0, 1, 0, W, 32'h10,      32'hDEADBEEF, 32'h0);
        vec("lw10",        0, 0, 1, 0, 0, W, 32'h10,      32'h0,        32'hDEADBEEF);
        vec("sb13",        0, 0, 0, 1, 0, B, 32'h13,      32'h12345680, 32'h0);
        vec("lb13",        0, 0, 1, 0, 0, B, 32'h13,      32'h0,        32'hFFFFFF80);
        vec("lbu13",       0, 0, 1, 0, 1, B, 32'h13,      32'h0,        32'h00000080);
        vec("lw10_b",      0, 0, 1, 0, 0, W, 32'h10,      32'h0,        32'h80ADBEEF);
        vec("lh12",        0, 0, 1, 0, 0, H, 32'h12,      32'h0,        32'hFFFF80AD);
        vec("lhu10",       0, 0, 1, 0, 1, H, 32'h10,      32'h0,        32'h0000BEEF);
        vec("sh12",        0, 0, 0, 1, 0, H, 32'h12,      32'hABCD7FFF, 32'h0);
        vec("lh12_b",      0, 0, 1, 0, 0, H, 32'h12,      32'h0,        32'h00007FFF);
        vec("lb11",        0, 0, 1, 0, 0, B, 32'h11,      32'h0,        32'hFFFFFFBE);
        vec("lw10_c",      0, 0, 1, 0, 0, W, 32'h10,      32'h0,        32'h7FFFBEEF);
        vec("alu_op",      0, 0, 0, 0, 0, W, 32'h44,      32'h0,        32'h0);
        vec("sw20",        0, 0, 0, 1, 0, W, 32'h20,      32'hCAFEF00D, 32'h0);
        vec("sh21_mis",    0, 0, 0, 1, 0, H, 32'h21,      32'h00001234, 32'h0);
        for (int i = 0; i < 10; i++)
            vec("err_hold",    0, 0, 0, 0, 0, W, 32'h48,      32'h0,        32'h0);
        vec("lw20",        0, 0, 1, 0, 0, W, 32'h20,      32'h0,        32'hCAFEF00D);
        vec("rst_err",     1, 0, 0, 0, 0, W, 32'h0,       32'h0,        32'h0);
        vec("lw22_mis",    0, 0, 1, 0, 0, W, 32'h22,      32'h0,        32'h0);
        vec("rst_err2",    1, 0, 0, 0, 0, W, 32'h0,       32'h0,        32'h0);
        vec("sw30",        0, 0, 0, 1, 0, W, 32'h30,      32'hAAAAAAAA, 32'h0);
        vec("lw30",        0, 0, 1, 0, 0, W, 32'h30,      32'h0,        32'hAAAAAAAA);
        vec("stall_sw30",  0, 1, 0, 1, 0, W, 32'h30,      32'hBBBBBBBB, 32'h0);
        vec("stall_sw34",  0, 1, 0, 1, 0, W, 32'h34,      32'hBBBBBBBB, 32'h0);
        vec("stall_mis",   0, 1, 0, 1, 0, W, 32'h31,      32'hBBBBBBBB, 32'h0);
        vec("stall_rd",    0, 1, 1, 0, 0, W, 32'h38,      32'h0,        32'h0);
        vec("lw30_b",      0, 0, 1, 0, 0, W, 32'h30,      32'h0,        32'hAAAAAAAA);
        vec("sw30_b",      0, 0, 0, 1, 0, W, 32'h30,      32'hCCCCCCCC, 32'h0);
        vec("lw30_c",      0, 0, 1, 0, 0, W, 32'h30,      32'h0,        32'hCCCCCCCC);
        vec("lw400",       0, 0, 1, 0, 0, W, 32'h400,     32'h0,        32'h11111111);
        vec("rbw400",      0, 0, 1, 1, 0, W, 32'h400,     32'h33333333, 32'h11111111);
        vec("lw0_b",       0, 0, 1, 0, 0, W, 32'h0,       32'h0,        32'h33333333);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, data-memory depth in 32-bit words (power of 2).
REQ-002 SHALL have ports `clk` (in, 1, system clock) and `rst` (in, 1, synchronous active-high reset). One clock only; reset polarity and synchronicity are fixed.
REQ-003 SHALL have input ports from the EX/MEM latch:
- `i_pcplus4` (32)
- `i_result` (32, ALU result / address)
- `i_dato2` (32, store data)
- `i_carry` (1)
- `i_writeRegister` (5)
- `i_memToReg`, `i_regWrite`, `i_memWrite`, `i_memRead` (1 each)
REQ-004 SHALL have input ports `i_memSize` (2; 00 byte, 01 half, 11 word) and `i_memUnsigned` (1, zero-extend loads).
REQ-005 SHALL have input port `i_stall` (1, hold the MEM/WB latch and block writes).
REQ-006 SHALL have output port `o_forward_dato_mem` (32) = `i_result`, combinational; it feeds the EX forwarding muxes.
REQ-007 SHALL have MEM/WB latch outputs, all registered: `o_pcplus4` (32), `o_result` (32), `o_readData` (32), `o_carry` (1), `o_writeRegister` (5), `o_memToReg` (1), `o_regWrite` (1).
REQ-008 SHALL have output port `o_addrError` (1), a sticky misalignment flag.

Function
REQ-009 Word index SHALL be `i_result[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored (wrap-around).
REQ-010 Misalignment is defined as: half with `addr[0]=1`, or word with `addr[1:0]!=0`.
REQ-011 A store SHALL occur at the clock edge when `i_memWrite=1`, `i_stall=0` and the access is aligned.
- byte: write lane `addr[1:0]` with `i_dato2[7:0]`
- half: write lanes by `addr[1]` with `i_dato2[15:0]`
- word: write the full word
- other lanes are unchanged; little-endian lane order.
REQ-012 A load SHALL extract the byte/half/word selected by address and size, sign-extend it (or zero-extend if `i_memUnsigned`), and register it into `o_readData` with latency 1 cycle.
REQ-013 When `i_memRead=0`, or the access is misaligned, `o_readData` SHALL be loaded with 0.
REQ-014 Simultaneous read and write of the same word: the read SHALL return the pre-write contents.
REQ-015 A misaligned access with `i_memRead` or `i_memWrite` set SHALL:
- suppress the write
- set `o_addrError` at the next edge; it stays 1 until reset.
REQ-016 With `i_stall=1`, all MEM/WB outputs SHALL hold their values, no memory write occurs, and `o_addrError` is not updated.
REQ-017 With `i_stall=0`, all other latch outputs SHALL copy their inputs at each edge.

Reset
REQ-018 On `rst=1` at an edge, all MEM/WB outputs and `o_addrError` SHALL become 0; reset overrides `i_stall`.
REQ-019 Data-memory contents SHALL NOT be cleared by reset, and a write presented in the same cycle as reset SHALL be suppressed.

Configuration
REQ-020 Macro `MEM_DEBUG_PORT_EN` SHALL add ports `i_dbg_addr` (in, log2(DEPTH_WORDS)) and `o_dbg_data` (out, 32). `o_dbg_data` is the registered word at `i_dbg_addr`, latency 1, and is 0 after reset.
REQ-021 Without `MEM_DEBUG_PORT_EN`, these ports and their logic SHALL be absent; function is otherwise identical.

Structure
REQ-022 Package `mips_pkg` SHALL hold the `MEM_SIZE_BYTE`/`MEM_SIZE_HALF`/`MEM_SIZE_WORD` encodings and the default depth constant.
REQ-023 Sub-module `data_memory` SHALL hold the byte-lane-writable array, the async read port and the optional debug port. Lane/extend logic and the latch are in `mem_stage`.

Verification
REQ-024 Word store then load: sw 0xDEADBEEF at 0x10, then lw 0x10 -> `o_readData`=0xDEADBEEF one cycle after the lw is presented.
REQ-025 Byte lanes: sb 0x80 at 0x13, then lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
REQ-026 Misalignment: sh at 0x21 -> word 0x20 unchanged, `o_addrError`=1 next cycle and still 1 ten cycles later; `rst` -> 0.
REQ-027 Stall: assert `i_stall` during an sw to 0x30 with `i_result` changing -> outputs frozen, memory at 0x30 unchanged; release -> the next sw succeeds.
REQ-028 Read-before-write and wrap: with DEPTH_WORDS=256, address 0x400 aliases 0x0; sw and lw to the same word in one cycle -> `o_readData` = old value.
REQ-029 Forwarding path: `o_forward_dato_mem` tracks `i_result` in the same cycle, including under stall and reset.
